reg_wb_arbiter: RTL



---
 rtl/reg_wb_arbiter_pkg.sv | 19 +
 rtl/reg_wb_arbiter_if.sv | 31 +++
 rtl/reg_wb_arbiter_rr.sv | 45 ++++
 rtl/reg_wb_arbiter.sv | 70 +++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file definitions (package rf_pkg) used by the write-back arbiter.
// Optional forwarding elsewhere in this slice is enabled by defining RF_WB_FWD_EN.
package rf_pkg;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int RF_WB_SRCS = 3;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  // Width of an index into n requesters; never zero so R=1 still builds.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus: requester handshake plus the register-file write port.
// Forwarding signals exist only when RF_WB_FWD_EN is defined.
interface reg_wb_arbiter_if #(
  parameter int N = rf_pkg::RF_ADDR_W,
  parameter int M = rf_pkg::RF_DATA_W,
  parameter int R = rf_pkg::RF_WB_SRCS
) ();
  logic           hold;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_addr;
  logic [R*M-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic           rf_we;
  logic [N-1:0]   rf_wrAddr;
  logic [M-1:0]   rf_wrData;
`ifdef RF_WB_FWD_EN
  logic [N-1:0]   rdAddr0, rdAddr1;
  logic [M-1:0]   rf_rdData0, rf_rdData1;
  logic [M-1:0]   fwdData0, fwdData1;

  modport master (output hold, req_valid, req_addr, req_data, rdAddr0, rdAddr1, rf_rdData0, rf_rdData1,
                  input  req_ready, rf_we, rf_wrAddr, rf_wrData, fwdData0, fwdData1);
  modport slave  (input  hold, req_valid, req_addr, req_data, rdAddr0, rdAddr1, rf_rdData0, rf_rdData1,
                  output req_ready, rf_we, rf_wrAddr, rf_wrData, fwdData0, fwdData1);
`else
  modport master (output hold, req_valid, req_addr, req_data,
                  input  req_ready, rf_we, rf_wrAddr, rf_wrData);
  modport slave  (input  hold, req_valid, req_addr, req_data,
                  output req_ready, rf_we, rf_wrAddr, rf_wrData);
`endif
endinterface

// File: rtl/reg_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first request found from ptr upward (mod R)
// and moves ptr just past each winner.
module rr_arbiter import rf_pkg::*; #(
  parameter  int R  = RF_WB_SRCS,
  localparam int IW = idx_w(R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [R-1:0]  req,
  input  logic          en,
  output logic [R-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [R-1:0]   masked;
  logic [2*R-1:0] rot2;
  logic           found;
  int             sum;

  // Rotate the request vector so bit 0 is the requester at ptr.
  always_comb begin
    masked  = req & {R{en}};
    rot2    = {masked, masked} >> ptr_q;
    found   = 1'b0;
    sum     = 0;
    gnt_idx = '0;
    for (int i = 0; i < R; i++) begin
      if (!found && rot2[i]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + i;
        if (sum >= R) sum = sum - R;
        gnt_idx = IW'(sum);
      end
    end
    gnt = '0;
    for (int i = 0; i < R; i++) gnt[i] = found && (gnt_idx == IW'(i));
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == IW'(R-1)) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, zero-register squash and a
// single staging register driving the write port. RF_WB_FWD_EN adds read forwarding.
module reg_wb_arbiter import rf_pkg::*; #(
  parameter  int N  = RF_ADDR_W,
  parameter  int M  = RF_DATA_W,
  parameter  int R  = RF_WB_SRCS,
  localparam int IW = idx_w(R)
) (
  input logic             clk,
  input logic             reset,
  reg_wb_arbiter_if.slave bus
);
  logic [R-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          xfer;
  logic [N-1:0]  sel_addr;
  logic [M-1:0]  sel_data;
  logic          we_q, we_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [M-1:0]  data_q, data_d;

  // Reset also gates the grant so no requester sees ready while it is asserted.
  rr_arbiter #(.R(R)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .en      (!bus.hold && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < R; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr = bus.req_addr[i*N +: N];
        sel_data = bus.req_data[i*M +: M];
      end
    end
    // Register 0 writes are consumed but never reach the file.
    we_d   = xfer && (sel_addr != '0);
    addr_d = xfer ? sel_addr : addr_q;
    data_d = xfer ? sel_data : data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.rf_we     = we_q;
  assign bus.rf_wrAddr = addr_q;
  assign bus.rf_wrData = data_q;

`ifdef RF_WB_FWD_EN
  assign bus.fwdData0 = (we_q && addr_q == bus.rdAddr0 && bus.rdAddr0 != '0) ? data_q : bus.rf_rdData0;
  assign bus.fwdData1 = (we_q && addr_q == bus.rdAddr1 && bus.rdAddr1 != '0) ? data_q : bus.rf_rdData1;
`endif
endmodule
